// File: rtl/axi_lite_regbank.sv
// AXI4-Lite slave register bank: parametrised width/count, read-only status registers,
// byte strobes, SLVERR on bad/RO accesses and one-cycle per-register write pulses.
module axi_lite_regbank #(
  parameter int                            C_S_AXI_DATA_WIDTH = 32,
  parameter int                            C_S_AXI_ADDR_WIDTH = 7,
  parameter int                            NUM_REGS           = 16,
  parameter logic [63:0]                   RO_MASK            = 64'h0,
  parameter logic [C_S_AXI_DATA_WIDTH-1:0] RESET_VALUE        = {C_S_AXI_DATA_WIDTH{1'b0}}
) (
  input  logic                                   S_AXI_ACLK,
  input  logic                                   S_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_AWADDR,
  input  logic [2:0]                             S_AXI_AWPROT,
  input  logic                                   S_AXI_AWVALID,
  output logic                                   S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
  input  logic                                   S_AXI_WVALID,
  output logic                                   S_AXI_WREADY,
  output logic [1:0]                             S_AXI_BRESP,
  output logic                                   S_AXI_BVALID,
  input  logic                                   S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_ARADDR,
  input  logic [2:0]                             S_AXI_ARPROT,
  input  logic                                   S_AXI_ARVALID,
  output logic                                   S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_RDATA,
  output logic [1:0]                             S_AXI_RRESP,
  output logic                                   S_AXI_RVALID,
  input  logic                                   S_AXI_RREADY,
  output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_out,
  input  logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] status_in,
  output logic [NUM_REGS-1:0]                    reg_wr_pulse
);

  localparam int DW   = C_S_AXI_DATA_WIDTH;
  localparam int NB   = DW / 8;
  localparam int LSB  = (DW == 64) ? 3 : 2;
  localparam int IDXW = C_S_AXI_ADDR_WIDTH - LSB;

  typedef enum logic [0:0] {W_IDLE = 1'b0, W_RESP = 1'b1} wstate_e;
  typedef enum logic [0:0] {R_IDLE = 1'b0, R_DATA = 1'b1} rstate_e;

  wstate_e wstate_r, wstate_next_s;
  rstate_e rstate_r, rstate_next_s;

  logic            awready_r, wready_r, aw_done_r, w_done_r, bvalid_r;
  logic [IDXW-1:0] awidx_r;
  logic [DW-1:0]   wdata_r;
  logic [NB-1:0]   wstrb_r;
  logic [1:0]      bresp_r;
  logic            arready_r, ar_done_r, rvalid_r;
  logic [IDXW-1:0] aridx_r;
  logic [DW-1:0]   rdata_r;
  logic [1:0]      rresp_r;
  logic [NUM_REGS-1:0] wr_pulse_r;
  logic [DW-1:0]   regs_r [NUM_REGS];

  logic                commit_s;
  logic [NUM_REGS-1:0] wsel_s;
  logic [DW-1:0]       rdata_s;
  logic                rhit_s;
  logic                unused_s;

  assign unused_s = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[LSB-1:0],
                      S_AXI_ARADDR[LSB-1:0], status_in};

  // State registers of both channel FSMs
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      wstate_r <= W_IDLE;
      rstate_r <= R_IDLE;
    end else begin
      wstate_r <= wstate_next_s;
      rstate_r <= rstate_next_s;
    end
  end

  // Write FSM next state; commit happens on the edge after both AW and W are held
  always_comb begin
    wstate_next_s = wstate_r;
    commit_s      = 1'b0;
    case (wstate_r)
      W_IDLE: begin
        if (aw_done_r && w_done_r) begin
          wstate_next_s = W_RESP;
          commit_s      = 1'b1;
        end else begin
          wstate_next_s = W_IDLE;
        end
      end
      W_RESP: begin
        if (S_AXI_BREADY) begin
          wstate_next_s = W_IDLE;
        end else begin
          wstate_next_s = W_RESP;
        end
      end
      default: wstate_next_s = W_IDLE;
    endcase
  end

  // Register select for the commit; RO and out-of-range targets select nothing
  always_comb begin
    wsel_s = {NUM_REGS{1'b0}};
    for (int i = 0; i < NUM_REGS; i++) begin
      wsel_s[i] = commit_s && (awidx_r == IDXW'(i)) && !RO_MASK[i];
    end
  end

  // Write address/data capture, response and write pulse
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      awready_r  <= 1'b0;
      wready_r   <= 1'b0;
      aw_done_r  <= 1'b0;
      w_done_r   <= 1'b0;
      awidx_r    <= {IDXW{1'b0}};
      wdata_r    <= {DW{1'b0}};
      wstrb_r    <= {NB{1'b0}};
      bvalid_r   <= 1'b0;
      bresp_r    <= 2'b00;
      wr_pulse_r <= {NUM_REGS{1'b0}};
    end else begin
      wr_pulse_r <= wsel_s;
      if (wstate_r == W_IDLE) begin
        if (S_AXI_AWVALID && awready_r) begin
          awidx_r   <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:LSB];
          aw_done_r <= 1'b1;
          awready_r <= 1'b0;
        end else begin
          awready_r <= !aw_done_r;
        end
        if (S_AXI_WVALID && wready_r) begin
          wdata_r  <= S_AXI_WDATA;
          wstrb_r  <= S_AXI_WSTRB;
          w_done_r <= 1'b1;
          wready_r <= 1'b0;
        end else begin
          wready_r <= !w_done_r;
        end
        if (commit_s) begin
          bvalid_r <= 1'b1;
          bresp_r  <= (|wsel_s) ? 2'b00 : 2'b10;
        end
      end else if (S_AXI_BREADY) begin
        bvalid_r  <= 1'b0;
        bresp_r   <= 2'b00;
        aw_done_r <= 1'b0;
        w_done_r  <= 1'b0;
        awready_r <= 1'b1;
        wready_r  <= 1'b1;
      end
    end
  end

  // Register file with byte-lane update
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_r[i] <= RESET_VALUE;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        for (int b = 0; b < NB; b++) begin
          if (wsel_s[i] && wstrb_r[b]) begin
            regs_r[i][b*8 +: 8] <= wdata_r[b*8 +: 8];
          end
        end
      end
    end
  end

  // Read FSM next state
  always_comb begin
    rstate_next_s = rstate_r;
    case (rstate_r)
      R_IDLE: begin
        if (ar_done_r) begin
          rstate_next_s = R_DATA;
        end else begin
          rstate_next_s = R_IDLE;
        end
      end
      R_DATA: begin
        if (S_AXI_RREADY) begin
          rstate_next_s = R_IDLE;
        end else begin
          rstate_next_s = R_DATA;
        end
      end
      default: rstate_next_s = R_IDLE;
    endcase
  end

  // Read mux: RO registers return the live status word, misses return zero
  always_comb begin
    rdata_s = {DW{1'b0}};
    rhit_s  = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      rdata_s = rdata_s | ((aridx_r == IDXW'(i)) ?
                (RO_MASK[i] ? status_in[i*DW +: DW] : regs_r[i]) : {DW{1'b0}});
      rhit_s  = rhit_s | (aridx_r == IDXW'(i));
    end
  end

  // Read address capture and data response
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      arready_r <= 1'b0;
      ar_done_r <= 1'b0;
      aridx_r   <= {IDXW{1'b0}};
      rvalid_r  <= 1'b0;
      rdata_r   <= {DW{1'b0}};
      rresp_r   <= 2'b00;
    end else if (rstate_r == R_IDLE) begin
      if (S_AXI_ARVALID && arready_r) begin
        aridx_r   <= S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:LSB];
        ar_done_r <= 1'b1;
        arready_r <= 1'b0;
      end else begin
        arready_r <= !ar_done_r;
      end
      if (ar_done_r) begin
        rvalid_r <= 1'b1;
        rdata_r  <= rdata_s;
        rresp_r  <= rhit_s ? 2'b00 : 2'b10;
      end
    end else if (S_AXI_RREADY) begin
      rvalid_r  <= 1'b0;
      ar_done_r <= 1'b0;
      arready_r <= 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
    assign reg_out[g*DW +: DW] = RO_MASK[g] ? {DW{1'b0}} : regs_r[g];
  end

  assign S_AXI_AWREADY = awready_r;
  assign S_AXI_WREADY  = wready_r;
  assign S_AXI_BVALID  = bvalid_r;
  assign S_AXI_BRESP   = bresp_r;
  assign S_AXI_ARREADY = arready_r;
  assign S_AXI_RVALID  = rvalid_r;
  assign S_AXI_RDATA   = rdata_r;
  assign S_AXI_RRESP   = rresp_r;
  assign reg_wr_pulse  = wr_pulse_r;

endmodule
